// File: rtl/soc_system_pio_status_in.sv
// Avalon-MM input PIO: synchronizes and debounces WIDTH status lines, captures
// selected edges into a write-1-to-clear register and raises a masked level irq.
module soc_system_pio_status_in #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] filtered_reg;
  logic [WIDTH-1:0] irqmask_reg;
  logic [WIDTH-1:0] edgesel_reg;
  logic [WIDTH-1:0] capture_reg;
  logic [WIDTH-1:0] update;
  logic [WIDTH-1:0] set_edge;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_writedata;

  assign wr_en            = chipselect & ~write_n;
  assign wr_data          = writedata[WIDTH-1:0];
  assign clr_mask         = (wr_en && address == 2'd3) ? wr_data : '0;
  assign unused_writedata = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= in_port;
      sync2_reg <= sync1_reg;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [CW-1:0] cnt_reg;

    assign update[gi]   = (sync2_reg[gi] != filtered_reg[gi]) && (cnt_reg == CNT_LAST);
    // New level differs from the select bit exactly when the direction matches.
    assign set_edge[gi] = update[gi] && (sync2_reg[gi] != edgesel_reg[gi]);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if ((sync2_reg[gi] == filtered_reg[gi]) || update[gi]) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filtered_reg <= '0;
      irqmask_reg  <= '0;
      edgesel_reg  <= '0;
      capture_reg  <= '0;
    end else begin
      filtered_reg <= (filtered_reg & ~update) | (sync2_reg & update);
      if (wr_en && address == 2'd1) irqmask_reg <= wr_data;
      if (wr_en && address == 2'd2) edgesel_reg <= wr_data;
      // A new edge overrides a simultaneous clear of the same bit.
      capture_reg <= (capture_reg & ~clr_mask) | set_edge;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = filtered_reg;
      2'd1:    rd_mux[WIDTH-1:0] = irqmask_reg;
      2'd2:    rd_mux[WIDTH-1:0] = edgesel_reg;
      default: rd_mux[WIDTH-1:0] = capture_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

  assign irq = |(capture_reg & irqmask_reg);

endmodule

// File: tb/tb_soc_system_pio_status_in.sv
// Directed bench for soc_system_pio_status_in (WIDTH=8, DEBOUNCE_CYCLES=4):
// register table plus hand sequences for edge timing, debounce, collision and reset.
module tb_soc_system_pio_status_in;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic        irq;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic        do_wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  soc_system_pio_status_in #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
      $display("check %-24s got %08h expected %08h ok", name, act, exp);
    end else begin
      $display("FAIL %-24s got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick(1);
    d = readdata;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;

    vecs[0] = '{1'b1, 2'd1, 32'h0000_00A5, 32'h0000_00A5};
    vecs[1] = '{1'b1, 2'd2, 32'h0000_003C, 32'h0000_003C};
    vecs[2] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0000_0009};
    vecs[3] = '{1'b1, 2'd1, 32'hFFFF_FF5A, 32'h0000_005A};
    vecs[4] = '{1'b0, 2'd2, 32'h0000_0000, 32'h0000_003C};
    vecs[5] = '{1'b1, 2'd1, 32'h0000_00A5, 32'h0000_00A5};

    reset = 1'b1; in_port = '0; address = '0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0;
    tick(3);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    tick(8);
    rd(2'd1, d); check("init_irqmask", d, 32'h0);
    rd(2'd2, d); check("init_edgesel", d, 32'h0);
    rd(2'd3, d); check("init_capture", d, 32'h0);

    // Rising capture on bit 0 with irq, exact latency
    wr(2'd1, 32'h01);
    wr(2'd2, 32'h00);
    in_port = 8'h01;
    tick(5);
    check("rise_irq_early", {31'b0, irq}, 32'h0);
    tick(1);
    check("rise_irq_at_6", {31'b0, irq}, 32'h1);
    rd(2'd3, d); check("rise_capture", d, 32'h01);
    rd(2'd0, d); check("rise_data", d, 32'h01);
    wr(2'd3, 32'h01);
    check("w1c_irq_low", {31'b0, irq}, 32'h0);
    rd(2'd3, d); check("w1c_capture", d, 32'h0);

    // Falling select on bit 1
    wr(2'd2, 32'h02);
    in_port = 8'h03;
    tick(10);
    rd(2'd3, d); check("fall_no_rise_cap", d, 32'h0);
    rd(2'd0, d); check("fall_data_high", d, 32'h03);
    in_port = 8'h01;
    tick(10);
    rd(2'd3, d); check("fall_capture", d, 32'h02);
    check("fall_irq_masked_off", {31'b0, irq}, 32'h0);
    rd(2'd0, d); check("fall_data_low", d, 32'h01);
    wr(2'd3, 32'hFF);

    // Debounce: 3-cycle glitch rejected, 4-cycle pulse accepted
    in_port = 8'h05;
    tick(3);
    in_port = 8'h01;
    tick(10);
    rd(2'd0, d); check("glitch3_data", d, 32'h01);
    rd(2'd3, d); check("glitch3_capture", d, 32'h0);
    address = 2'd0;
    tick(1);
    in_port = 8'h05;
    tick(4);
    in_port = 8'h01;
    tick(3);
    check("pulse4_data", readdata, 32'h05);
    tick(10);
    rd(2'd0, d); check("pulse4_data_back", d, 32'h01);
    rd(2'd3, d); check("pulse4_capture", d, 32'h04);
    wr(2'd3, 32'hFF);

    // W1C landing on the same edge as a new bit-3 capture
    wr(2'd1, 32'h08);
    in_port = 8'h09;
    tick(5);
    wr(2'd3, 32'h08);
    check("collide_irq", {31'b0, irq}, 32'h1);
    rd(2'd3, d); check("collide_capture", d, 32'h08);
    wr(2'd3, 32'h08);
    check("collide_clear_irq", {31'b0, irq}, 32'h0);

    // Register table
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, d);
      check($sformatf("table_%0d", i), d, vecs[i].exp);
    end

    // Back-to-back reads of the whole map
    address = 2'd0; tick(1); check("b2b_data", readdata, 32'h09);
    address = 2'd1; tick(1); check("b2b_irqmask", readdata, 32'hA5);
    address = 2'd2; tick(1); check("b2b_edgesel", readdata, 32'h3C);
    address = 2'd3; tick(1); check("b2b_capture", readdata, 32'h00);

    // Pending captures, then asynchronous reset
    wr(2'd1, 32'hFF);
    in_port = 8'hFF;
    tick(8);
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    rd(2'd3, d); check("pre_reset_capture", d, 32'hC2);
    in_port = 8'h00;
    tick(2);
    in_port = 8'hFF;
    tick(2);
    reset = 1'b1;
    #1;
    check("async_reset_irq", {31'b0, irq}, 32'h0);
    check("async_reset_rd", readdata, 32'h0);
    tick(2);
    address = 2'd0;
    reset = 1'b0;
    tick(6);
    check("post_reset_data_6", readdata, 32'h0);
    tick(1);
    check("post_reset_data_7", readdata, 32'hFF);
    rd(2'd3, d); check("post_reset_capture", d, 32'hFF);
    rd(2'd1, d); check("post_reset_irqmask", d, 32'h0);
    check("post_reset_irq", {31'b0, irq}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
